// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 to ZX Spectrum keyboard matrix block:
// matrix row/column indices, the scancode map entry and the PS/2 codes the top decodes itself.
package ps2_kbd_pkg;

    localparam int ROW_W = 3;
    localparam int COL_W = 3;

    localparam logic [ROW_W-1:0] ROW_CAPS  = 3'd0;
    localparam logic [ROW_W-1:0] ROW_ASDFG = 3'd1;
    localparam logic [ROW_W-1:0] ROW_QWERT = 3'd2;
    localparam logic [ROW_W-1:0] ROW_12345 = 3'd3;
    localparam logic [ROW_W-1:0] ROW_09876 = 3'd4;
    localparam logic [ROW_W-1:0] ROW_POIUY = 3'd5;
    localparam logic [ROW_W-1:0] ROW_ENTER = 3'd6;
    localparam logic [ROW_W-1:0] ROW_SPACE = 3'd7;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_F5     = 8'h03;

    typedef struct packed {
        logic             valid;
        logic             caps_virtual;
        logic [ROW_W-1:0] row2;
        logic [COL_W-1:0] col2;
        logic             valid2;
        logic [ROW_W-1:0] row1;
        logic [COL_W-1:0] col1;
    } map_entry_t;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] scancode;
    } kbd_event_t;

    function automatic map_entry_t key(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        key = '{valid: 1'b1, caps_virtual: 1'b0, row2: '0, col2: '0,
                valid2: 1'b0, row1: row, col1: col};
    endfunction

    // Composite key: primary is the virtual CAPS SHIFT, secondary is the real matrix key.
    function automatic map_entry_t comp(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        comp = '{valid: 1'b1, caps_virtual: 1'b1, row2: row, col2: col,
                 valid2: 1'b1, row1: ROW_CAPS, col1: '0};
    endfunction

    function automatic logic is_shift(input kbd_event_t ev);
        is_shift = !ev.extended && (ev.scancode == SC_LSHIFT || ev.scancode == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_scancode_map.sv
// Registered lookup from {extended, scancode} to a Spectrum matrix map entry (1-cycle latency).
module ps2_scancode_map
    import ps2_kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       extended,
    input  logic [7:0] scancode,
    output map_entry_t entry
);

    function automatic map_entry_t lookup(input logic [8:0] code);
        lookup = '0;
        case (code)
            9'h01A: lookup = key(ROW_CAPS, 3'd1);  9'h022: lookup = key(ROW_CAPS, 3'd2);
            9'h021: lookup = key(ROW_CAPS, 3'd3);  9'h02A: lookup = key(ROW_CAPS, 3'd4);
            9'h01C: lookup = key(ROW_ASDFG, 3'd0); 9'h01B: lookup = key(ROW_ASDFG, 3'd1);
            9'h023: lookup = key(ROW_ASDFG, 3'd2); 9'h02B: lookup = key(ROW_ASDFG, 3'd3);
            9'h034: lookup = key(ROW_ASDFG, 3'd4);
            9'h015: lookup = key(ROW_QWERT, 3'd0); 9'h01D: lookup = key(ROW_QWERT, 3'd1);
            9'h024: lookup = key(ROW_QWERT, 3'd2); 9'h02D: lookup = key(ROW_QWERT, 3'd3);
            9'h02C: lookup = key(ROW_QWERT, 3'd4);
            9'h016: lookup = key(ROW_12345, 3'd0); 9'h01E: lookup = key(ROW_12345, 3'd1);
            9'h026: lookup = key(ROW_12345, 3'd2); 9'h025: lookup = key(ROW_12345, 3'd3);
            9'h02E: lookup = key(ROW_12345, 3'd4);
            9'h045: lookup = key(ROW_09876, 3'd0); 9'h046: lookup = key(ROW_09876, 3'd1);
            9'h03E: lookup = key(ROW_09876, 3'd2); 9'h03D: lookup = key(ROW_09876, 3'd3);
            9'h036: lookup = key(ROW_09876, 3'd4);
            9'h04D: lookup = key(ROW_POIUY, 3'd0); 9'h044: lookup = key(ROW_POIUY, 3'd1);
            9'h043: lookup = key(ROW_POIUY, 3'd2); 9'h03C: lookup = key(ROW_POIUY, 3'd3);
            9'h035: lookup = key(ROW_POIUY, 3'd4);
            9'h05A, 9'h15A: lookup = key(ROW_ENTER, 3'd0);
            9'h04B: lookup = key(ROW_ENTER, 3'd1); 9'h042: lookup = key(ROW_ENTER, 3'd2);
            9'h03B: lookup = key(ROW_ENTER, 3'd3); 9'h033: lookup = key(ROW_ENTER, 3'd4);
            9'h029: lookup = key(ROW_SPACE, 3'd0);
            9'h03A: lookup = key(ROW_SPACE, 3'd2); 9'h031: lookup = key(ROW_SPACE, 3'd3);
            9'h032: lookup = key(ROW_SPACE, 3'd4);
            {1'b0, SC_CTRL}, {1'b1, SC_CTRL}: lookup = key(ROW_SPACE, 3'd1);
            {1'b1, SC_LEFT}:  lookup = comp(ROW_12345, 3'd4);
            {1'b1, SC_DOWN}:  lookup = comp(ROW_09876, 3'd4);
            {1'b1, SC_UP}:    lookup = comp(ROW_09876, 3'd3);
            {1'b1, SC_RIGHT}: lookup = comp(ROW_09876, 3'd2);
            {1'b0, SC_BKSP}:  lookup = comp(ROW_09876, 3'd0);
            default:          lookup = '0;
        endcase
    endfunction

    // Loaded only when an event is issued, so the entry stays stable through APPLY1/APPLY2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entry <= '0;
        else if (load) entry <= lookup({extended, scancode});
    end

endmodule

// File: rtl/ps2_kbd_matrix.sv
// PS/2 key events -> ZX Spectrum 8x5 keyboard matrix with combinational port-FE column read.
// Optional PS2_KBD_MATRIX_NMI_KEY_EN adds an nmi_req pulse on F5 make.
module ps2_kbd_matrix
    import ps2_kbd_pkg::*;
#(
    parameter int CAPS_CNT_W = 2
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kb_interrupt,
    input  logic [7:0] scancode,
    input  logic       released,
    input  logic       extended,
    input  logic [7:0] rows,
    output logic [4:0] cols,
    output logic       busy,
    output logic       overflow
`ifdef PS2_KBD_MATRIX_NMI_KEY_EN
    ,
    output logic       nmi_req
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_APPLY1 = 2'd2;
    localparam logic [1:0] S_APPLY2 = 2'd3;

    localparam logic [CAPS_CNT_W-1:0] CAPS_MAX = '1;
    localparam logic [CAPS_CNT_W-1:0] CAPS_ONE = CAPS_CNT_W'(1);

    logic [1:0]            state;
    logic                  pend_full;
    kbd_event_t            pend_ev;
    kbd_event_t            cur_ev;
    map_entry_t            entry;
    logic [7:0][4:0]       matrix;
    logic [7:0][4:0]       eff;
    logic                  phys_caps;
    logic [CAPS_CNT_W-1:0] virt_caps;
    logic                  issue;

    assign issue = (state == S_IDLE) && pend_full;
    assign busy  = (state != S_IDLE) || pend_full;

    ps2_scancode_map u_map (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (issue),
        .extended (pend_ev.extended),
        .scancode (pend_ev.scancode),
        .entry    (entry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend_ev   <= '0;
            cur_ev    <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (issue) begin
                pend_full <= 1'b0;
                cur_ev    <= pend_ev;
            end
            if (kb_interrupt) begin
                if (!pend_full || issue) begin
                    pend_full <= 1'b1;
                    pend_ev   <= '{extended: extended, released: released, scancode: scancode};
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // NOTE: the matrix is a handful of flops, not a RAM, so it is reset and keys never stick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            matrix    <= '0;
            phys_caps <= 1'b0;
            virt_caps <= '0;
        end else begin
            case (state)
                S_IDLE:   if (pend_full) state <= S_LOOKUP;
                S_LOOKUP: state <= S_APPLY1;
                S_APPLY1: begin
                    state <= (entry.valid && entry.valid2) ? S_APPLY2 : S_IDLE;
                    if (is_shift(cur_ev)) begin
                        phys_caps <= !cur_ev.released;
                    end else if (entry.valid && entry.caps_virtual) begin
                        if (cur_ev.released) begin
                            if (virt_caps != '0) virt_caps <= virt_caps - CAPS_ONE;
                        end else if (!matrix[entry.row2][entry.col2] && virt_caps != CAPS_MAX) begin
                            virt_caps <= virt_caps + CAPS_ONE;
                        end
                    end else if (entry.valid) begin
                        matrix[entry.row1][entry.col1] <= !cur_ev.released;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    matrix[entry.row2][entry.col2] <= !cur_ev.released;
                end
            endcase
        end
    end

`ifdef PS2_KBD_MATRIX_NMI_KEY_EN
    logic f5_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_req <= 1'b0;
            f5_held <= 1'b0;
        end else begin
            nmi_req <= 1'b0;
            if (state == S_APPLY1 && !cur_ev.extended && cur_ev.scancode == SC_F5) begin
                nmi_req <= !cur_ev.released && !f5_held;
                f5_held <= !cur_ev.released;
            end
        end
    end
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        eff       = matrix;
        eff[0][0] = phys_caps || (virt_caps != '0);
        cols      = '1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (eff[r][c] && !rows[r]) cols[c] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Scoreboard bench for ps2_kbd_matrix: stimulus queues expected cols/busy, a negedge monitor checks.
module tb_ps2_kbd_matrix;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kb_interrupt = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       released = 1'b0;
    logic       extended = 1'b0;
    logic [7:0] rows = 8'h00;
    logic [4:0] cols;
    logic       busy;
    logic       overflow;
`ifdef PS2_KBD_MATRIX_NMI_KEY_EN
    logic       nmi_req;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int ovf_seen = 0;
    int ovf_exp = 0;
    int nmi_seen = 0;
    int nmi_exp = 0;

    typedef struct {
        string      name;
        logic       chk_cols;
        logic [4:0] cols;
        logic       chk_busy;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    ps2_kbd_matrix #(.CAPS_CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kb_interrupt (kb_interrupt),
        .scancode     (scancode),
        .released     (released),
        .extended     (extended),
        .rows         (rows),
        .cols         (cols),
        .busy         (busy),
        .overflow     (overflow)
`ifdef PS2_KBD_MATRIX_NMI_KEY_EN
        ,
        .nmi_req      (nmi_req)
`endif
    );

    // Monitor: samples mid-cycle, counts pulses and drains the scoreboard.
    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_seen++;
`ifdef PS2_KBD_MATRIX_NMI_KEY_EN
        if (nmi_req === 1'b1) nmi_seen++;
`endif
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk_cols) begin
                n_cmp++;
                if (cols !== mon_e.cols) begin
                    n_err++;
                    $display("FAIL %s: cols=%h expected %h (rows=%h)", mon_e.name, cols, mon_e.cols, rows);
                end
            end
            if (mon_e.chk_busy) begin
                n_cmp++;
                if (busy !== mon_e.busy) begin
                    n_err++;
                    $display("FAIL %s: busy=%b expected %b", mon_e.name, busy, mon_e.busy);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ext, input logic rel, input logic [7:0] code);
        kb_interrupt = 1'b1;
        extended     = ext;
        released     = rel;
        scancode     = code;
        tick();
        kb_interrupt = 1'b0;
    endtask

    task automatic expect_cols(input string name, input logic [7:0] r, input logic [4:0] c);
        rows = r;
        sb.push_back('{name, 1'b1, c, 1'b0, 1'b0});
        tick();
    endtask

    task automatic expect_all(input string name, input logic [7:0] r, input logic [4:0] c, input logic b);
        rows = r;
        sb.push_back('{name, 1'b1, c, 1'b1, b});
        tick();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, k);
        end
    endtask

    task automatic press_idle(input logic ext, input logic rel, input logic [7:0] code);
        send(ext, rel, code);
        wait_idle("idle");
    endtask

    initial begin
        tick();
        expect_all("reset_hold", 8'h00, 5'h1F, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_all("reset_state", 8'h00, 5'h1F, 1'b0);

        // A make: latency check, visible from the third edge after capture
        send(1'b0, 1'b0, 8'h1C);
        expect_all("a_lat0", 8'hFD, 5'h1F, 1'b1);
        expect_cols("a_lat1", 8'hFD, 5'h1F);
        expect_cols("a_lat2", 8'hFD, 5'h1F);
        expect_cols("a_set", 8'hFD, 5'h1E);
        expect_cols("a_row0", 8'hFE, 5'h1F);
        wait_idle("a_make");
        press_idle(1'b0, 1'b1, 8'h1C);
        expect_cols("a_release", 8'hFD, 5'h1F);

        // Left arrow = CAPS + 5, with physical shift overlapping
        press_idle(1'b1, 1'b0, 8'h6B);
        expect_cols("left_caps", 8'hFE, 5'h1E);
        expect_cols("left_5", 8'hF7, 5'h0F);
        press_idle(1'b0, 1'b0, 8'h12);
        press_idle(1'b1, 1'b1, 8'h6B);
        expect_cols("shift_caps", 8'hFE, 5'h1E);
        expect_cols("left_5_clr", 8'hF7, 5'h1F);
        press_idle(1'b0, 1'b1, 8'h12);
        expect_cols("shift_rel", 8'h00, 5'h1F);

        // Down arrow: CAPS at N+3, secondary at N+4; typematic make is idempotent
        send(1'b1, 1'b0, 8'h72);
        expect_cols("down_lat0", 8'hEE, 5'h1F);
        expect_cols("down_lat1", 8'hEE, 5'h1F);
        expect_cols("down_lat2", 8'hEE, 5'h1F);
        expect_cols("down_caps", 8'hEE, 5'h1E);
        expect_cols("down_6", 8'hEE, 5'h0E);
        wait_idle("down_make");
        press_idle(1'b1, 1'b0, 8'h72);
        press_idle(1'b1, 1'b1, 8'h72);
        expect_cols("down_typematic", 8'hEE, 5'h1F);

        // Backspace = CAPS + 0, right shift alone
        press_idle(1'b0, 1'b0, 8'h66);
        expect_cols("bksp_caps", 8'hFE, 5'h1E);
        expect_cols("bksp_0", 8'hEF, 5'h1E);
        press_idle(1'b0, 1'b1, 8'h66);
        expect_cols("bksp_rel", 8'h00, 5'h1F);
        press_idle(1'b0, 1'b0, 8'h59);
        expect_cols("rshift", 8'hFE, 5'h1E);
        press_idle(1'b0, 1'b1, 8'h59);
        expect_cols("rshift_rel", 8'hFE, 5'h1F);

        // Back-to-back events: the third is dropped
        ovf_exp = ovf_exp + 1;
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h1B);
        send(1'b0, 1'b0, 8'h23);
        wait_idle("overflow_burst");
        expect_cols("ovf_as_not_d", 8'hFD, 5'h1C);
        press_idle(1'b0, 1'b1, 8'h1C);
        press_idle(1'b0, 1'b1, 8'h1B);
        expect_cols("ovf_cleared", 8'hFD, 5'h1F);

        // Unmapped code, then SYM via extended ctrl
        press_idle(1'b0, 1'b0, 8'h07);
        expect_all("unmapped", 8'h00, 5'h1F, 1'b0);
        press_idle(1'b1, 1'b0, 8'h14);
        expect_cols("sym", 8'h7F, 5'h1D);
        press_idle(1'b0, 1'b1, 8'h14);
        expect_cols("sym_rel", 8'h7F, 5'h1F);
        press_idle(1'b0, 1'b0, 8'h1A);
        expect_cols("z", 8'hFE, 5'h1D);
        press_idle(1'b0, 1'b1, 8'h1A);

`ifdef PS2_KBD_MATRIX_NMI_KEY_EN
        nmi_exp = nmi_exp + 1;
        press_idle(1'b0, 1'b0, 8'h03);
        press_idle(1'b0, 1'b0, 8'h03);
        expect_cols("f5_no_matrix", 8'h00, 5'h1F);
        press_idle(1'b0, 1'b1, 8'h03);
`endif

        // SPACE and ENTER held, then async reset in the middle of APPLY1
        press_idle(1'b0, 1'b0, 8'h29);
        press_idle(1'b0, 1'b0, 8'h5A);
        expect_cols("space", 8'h7F, 5'h1E);
        expect_cols("enter", 8'hBF, 5'h1E);
        send(1'b0, 1'b0, 8'h45);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        expect_all("mid_reset", 8'h00, 5'h1F, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_all("after_reset", 8'h00, 5'h1F, 1'b0);

        tick();
        tick();
        n_cmp++;
        if (ovf_seen != ovf_exp) begin
            n_err++;
            $display("FAIL overflow_pulses: saw %0d cycles high, expected %0d", ovf_seen, ovf_exp);
        end
`ifdef PS2_KBD_MATRIX_NMI_KEY_EN
        n_cmp++;
        if (nmi_seen != nmi_exp) begin
            n_err++;
            $display("FAIL nmi_pulses: saw %0d cycles high, expected %0d", nmi_seen, nmi_exp);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_matrix.md
Name: ps2_kbd_matrix

Overview:
- Downstream consumer of the PS/2 receive stage. Takes decoded key events (`scancode`, `released`, `extended`, one-cycle `kb_interrupt`) and maintains the 8x5 ZX Spectrum keyboard matrix.
- The ULA port-FE read path drives `rows` (address high byte, active-low) and gets `cols` (active-low) back combinationally.
- PC keys with no direct Spectrum key, such as arrows and backspace, are synthesised as CAPS SHIFT plus a second matrix key.

Parameters:
- `CAPS_CNT_W`, 2: width of the saturating count of synthesised CAPS SHIFT presses.

Ports:
- `clk` in 1: system clock, same domain as the PS/2 receive stage.
- `rst_n` in 1: reset, asynchronous and active-low.
- `kb_interrupt` in 1: one-cycle strobe, new key event valid.
- `scancode` in 8: make code of the event.
- `released` in 1: 1 = key released, 0 = key pressed.
- `extended` in 1: 1 = E0-prefixed code.
- `rows` in 8: `rows[r]`=0 selects matrix row r (A8..A15).
- `cols` out 5: active-low column read, combinational from matrix and `rows`.
- `busy` out 1: event pipeline not idle.
- `overflow` out 1: one-cycle pulse when an event is dropped.

Behaviour:
- Matrix rows (col0..col4):
  - r0 CAPS,Z,X,C,V
  - r1 A,S,D,F,G
  - r2 Q,W,E,R,T
  - r3 1,2,3,4,5
  - r4 0,9,8,7,6
  - r5 P,O,I,U,Y
  - r6 ENTER,L,K,J,H
  - r7 SPACE,SYM,M,N,B
- State: `matrix[7:0][4:0]` (1 = pressed), `phys_caps` bit, `virt_caps` counter (`CAPS_CNT_W` bits).
- `matrix[0][0]` reads as `phys_caps | (virt_caps != 0)`.
- `cols[c] = ~|( matrix[r][c] & ~rows[r] )` over r=0..7. This is purely combinational; a row change is reflected in the same cycle.
- Reset (`rst_n`=0, async):
  - matrix, `phys_caps` and `virt_caps` cleared, so `cols`=5'h1F for any `rows`.
  - FSM to IDLE, pending slot empty.
  - `busy`=0, `overflow`=0.
- Input capture: the event `{extended, released, scancode}` is latched into a 1-entry pending slot on the `kb_interrupt` cycle.
  - If the slot is already full, the new event is dropped, `overflow`=1 for one cycle, and the slot keeps the old event.
- FSM:
  - IDLE: pending full -> LOOKUP. The slot is freed and the event is issued to the map. A new event may be captured in this same cycle.
  - LOOKUP: one cycle; the map output is registered -> APPLY1.
  - APPLY1: apply primary key -> APPLY2 if a secondary is valid, else IDLE.
  - APPLY2: apply secondary -> IDLE.
- Apply rule, normal keys: press sets `matrix[row][col]`; release clears it.
- Apply rule, `phys_caps`: PC left shift (12) and right shift (59) set/clear `phys_caps` instead of a matrix bit.
- Apply rule, composite keys (map flags `caps_virtual`): press increments `virt_caps`, saturating at max; release decrements it, saturating at 0. The second key follows the normal rule.
- Unmapped codes pass through LOOKUP and APPLY1 with no state change.
- Latency: `kb_interrupt` in cycle N -> `cols` reflects a single key from N+3; the composite second key appears from N+4.
- `busy` = (state != IDLE) | pending full.
- Required mappings:
  - 1C->r1c0 (A), 1A->r0c1 (Z), 16->r3c0 (1), 45->r4c0 (0).
  - 29->r7c0 (SPACE), 5A->r6c0 (ENTER), 14/E0 14->r7c1 (SYM).
  - E0 6B->CAPS+r3c4, E0 72->CAPS+r4c4, E0 75->CAPS+r4c3, E0 74->CAPS+r4c2.
  - 66->CAPS+r4c0.
  - Full alphanumeric set per the row table above.
- Repeated make of a held key (typematic) is idempotent for normal keys. For composite keys it is idempotent as well: a composite press while its own secondary bit is already set does not increment `virt_caps`.

Optional Feature:
- Macro `PS2_KBD_MATRIX_NMI_KEY_EN`.
- When defined: adds output `nmi_req` (1 bit, reset 0), pulsed for one cycle when F5 (03) is pressed (make, not repeat, not release). F5 does not touch the matrix.
- When undefined: no port, F5 is unmapped, and the port list is as above.

Decomposition:
- Package `ps2_kbd_pkg`:
  - row/column index constants: `ROW_CAPS`=0 ... `ROW_SPACE`=7, `COL_W`=3, `ROW_W`=3.
  - map-entry typedef `{valid, caps_virtual, row2, col2, valid2, row1, col1}`.
  - PS/2 code constants for shift, ctrl and arrows.
- Sub-module `ps2_scancode_map`: registered lookup `{extended, scancode}` -> map-entry, 1-cycle latency, case-table or ROM.

Test Plan:
- Reset, `rows`=8'h00 -> `cols`=5'h1F; `busy`=0.
- Event 1C make -> at N+3, `rows`=8'hFD gives `cols`=5'h1E and `rows`=8'hFE gives 5'h1F. Then 1C release -> `cols`=5'h1F with `rows`=8'hFD.
- E0 6B make -> `rows`=8'hFE `cols`=5'h1E, `rows`=8'hF7 `cols`=5'h0F. Hold left shift (12), release E0 6B -> CAPS stays pressed, bit r3c4 cleared. Release 12 -> all 5'h1F.
- Three `kb_interrupt` on consecutive cycles (1C, 1B, 23) -> third dropped with `overflow` pulse; A and S set, D not set.
- Press 29 and 5A, then assert `rst_n`=0 mid-APPLY1 of a third event -> immediately `cols`=5'h1F for `rows`=8'h00; `busy`=0.
- With `PS2_KBD_MATRIX_NMI_KEY_EN`: F5 make -> `nmi_req` high exactly one cycle; repeated make while held -> no pulse; matrix unchanged.
